// File: rtl/vedic_pkg.sv
// Shared constants and elaboration helpers for the pipelined Vedic multiplier.
package vedic_pkg;

    localparam int BASE_W = 4;

    function automatic bit width_legal(input int width);
        return (width == 8) || (width == 16) || (width == 32) || (width == 64);
    endfunction

    // Each halving of the operand width down to the 4x4 base is one recursion level.
    function automatic int split_levels(input int width);
        return $clog2(width / BASE_W);
    endfunction

    // One registered 4x4 stage plus two register stages per recursion level.
    function automatic int core_latency(input int width);
        return 2 * split_levels(width) + 1;
    endfunction

    // Core plus the sign/magnitude front stage and the negate back stage.
    function automatic int mult_latency(input int width);
        return core_latency(width) + 2;
    endfunction

endpackage

// File: rtl/vedic_mul_core.sv
// Unsigned WIDTH x WIDTH Vedic core: recursive split into four half-width cores down
// to registered 4x4 products. Every register advances only when en=1.
module vedic_mul_core
    import vedic_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               en,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);

    localparam int PW = 2 * WIDTH;

    if (WIDTH == BASE_W) begin : g_base
        logic [PW-1:0] prod_q;

        // NOTE: datapath registers carry no reset; the stage-valid bits in the wrapper
        // decide whether their contents mean anything, so the wide buses stay reset-free.
        always_ff @(posedge clk) begin
            if (en) begin
                prod_q <= PW'(a) * PW'(b);
            end
        end

        assign p = prod_q;
    end else begin : g_split
        localparam int H  = WIDTH / 2;
        localparam int MW = WIDTH + 2;

        logic [WIDTH-1:0] ll, lh, hl, hh;

        vedic_mul_core #(.WIDTH(H)) u_ll (.clk, .en, .a(a[H-1:0]),     .b(b[H-1:0]),     .p(ll));
        vedic_mul_core #(.WIDTH(H)) u_lh (.clk, .en, .a(a[H-1:0]),     .b(b[WIDTH-1:H]), .p(lh));
        vedic_mul_core #(.WIDTH(H)) u_hl (.clk, .en, .a(a[WIDTH-1:H]), .b(b[H-1:0]),     .p(hl));
        vedic_mul_core #(.WIDTH(H)) u_hh (.clk, .en, .a(a[WIDTH-1:H]), .b(b[WIDTH-1:H]), .p(hh));

        logic [MW-1:0]    cross_q;
        logic [WIDTH-1:0] ll_a_q, hh_a_q;
        logic [MW-1:0]    mid_q;
        logic [H-1:0]     ll_lo_q;
        logic [WIDTH-1:0] hh_b_q;

        // NOTE: non-blocking assignments make stage B read the previous stage A contents,
        // which is exactly the two-register split of the cross-term addition.
        always_ff @(posedge clk) begin
            if (en) begin
                cross_q <= MW'(lh) + MW'(hl);
                ll_a_q  <= ll;
                hh_a_q  <= hh;
                mid_q   <= cross_q + MW'(ll_a_q[WIDTH-1:H]);
                ll_lo_q <= ll_a_q[H-1:0];
                hh_b_q  <= hh_a_q;
            end
        end

        // Composition is combinational and lands in the consumer's first register stage.
        assign p = (PW'(hh_b_q) << WIDTH) + (PW'(mid_q) << H) + PW'(ll_lo_q);
    end

endmodule

// File: rtl/vedic_mult_pipe.sv
// Pipelined signed/unsigned Vedic multiplier with valid/ready handshake, pass-through
// tag and one global stall enable shared by every pipeline register.
module vedic_mult_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int LATENCY  = mult_latency(WIDTH);
    localparam int SB_DEPTH = LATENCY - 1;

    if (!width_legal(WIDTH)) begin : g_bad_width
        $error("vedic_mult_pipe: WIDTH must be 8, 16, 32 or 64");
    end

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             is_signed);
        return (is_signed && x[WIDTH-1]) ? -x : x;
    endfunction

    // Sideband index k travels alongside pipeline stage k+1; the last entry lines up
    // with the core output feeding the negate stage.
    logic [WIDTH-1:0]    a_mag_q, b_mag_q;
    logic [SB_DEPTH-1:0] vld_q, neg_q;
    logic [TAG_W-1:0]    tag_q [SB_DEPTH];
    logic [2*WIDTH-1:0]  core_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (en) begin
            vld_q     <= {vld_q[SB_DEPTH-2:0], in_valid};
            out_valid <= vld_q[SB_DEPTH-1];
            if (vld_q[SB_DEPTH-1]) begin
                out_result <= neg_q[SB_DEPTH-1] ? -core_p : core_p;
                out_tag    <= tag_q[SB_DEPTH-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            a_mag_q  <= magnitude(in_a, in_signed);
            b_mag_q  <= magnitude(in_b, in_signed);
            neg_q    <= {neg_q[SB_DEPTH-2:0], in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1])};
            tag_q[0] <= in_tag;
            for (int i = 1; i < SB_DEPTH; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    vedic_mul_core #(.WIDTH(WIDTH)) u_core (
        .clk (clk),
        .en  (en),
        .a   (a_mag_q),
        .b   (b_mag_q),
        .p   (core_p)
    );

endmodule

// File: doc/vedic_mult_pipe.md
Name: vedic_mult_pipe

Overview:
Parametrised, fully pipelined Vedic multiplier that generalises the fixed 16x16 multiplier to WIDTH in {8,16,32,64}.
- Adds per-transaction signed/unsigned mode, a valid/ready handshake with back-pressure stall, and a pass-through tag.
- Sits in the matrix-multiplier datapath between the operand fetch stage and the accumulator.
- Accepts one product per cycle when not stalled.

Parameters:
WIDTH, 16, operand width; legal values 8, 16, 32, 64 (elaboration error otherwise)
TAG_W, 4, width of the sideband tag carried alongside each operand pair
LATENCY, derived (not overridable), 2*log2(WIDTH/4)+3 cycles; 5/7/9/11 for WIDTH 8/16/32/64

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept this cycle
in_a  in  WIDTH  multiplicand
in_b  in  WIDTH  multiplier
in_signed  in  1  1 = two's-complement operands, 0 = unsigned
in_tag  in  TAG_W  sideband, returned unchanged with the result
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_result  out  2*WIDTH  product (signed or unsigned per transaction)
out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset: on rst=1 at posedge, all stage-valid bits are cleared, and out_valid, out_result and out_tag are set to 0. In-flight transactions are discarded, not completed. in_ready=1 in the cycle after reset deasserts.
- Global enable: en = !out_valid || out_ready. All pipeline registers, including data, valid, tag and sign, advance only when en=1. When en=0 everything holds.
- in_ready = en (combinational). A transfer occurs when in_valid && in_ready.
- Bubbles propagate as valid=0 stages. Data registers in bubble stages are don't-care, but out_result must hold its value whenever out_valid=0 and en=0.
- Latency: a transaction accepted at cycle t appears with out_valid=1 at cycle t+LATENCY when never stalled. Each stalled cycle adds exactly one.
- Throughput: one result per cycle with out_ready held at 1.
- Stage 1 (sign/magnitude):
  - If in_signed, register |a|, |b| (WIDTH-bit unsigned; |-2^(W-1)| = 2^(W-1) fits) and neg = a[W-1]^b[W-1].
  - Otherwise register a, b and neg = 0.
- Stage 2: 4x4 base products, registered.
- Each doubling level (4->8, 8->16, ...) uses 2 register stages:
  - Stage A registers the cross-term sum hi*lo + lo*hi, which is 2 bits wider than the cross term.
  - Stage B adds the upper half of lo*lo to the Stage A sum, with the lo*lo low half and hi*hi delayed in matching registers.
  - The final composition at the next level's Stage A is hi*hi<<W + carry, exactly as in the existing fixed-width multiplier.
- Final stage: out_result = neg ? -P : P on 2*WIDTH bits, registered into out_result.
  - Unsigned: 0..(2^W-1)^2.
  - Signed: range -2^(2W-2)+2^(W-1) .. 2^(2W-2); both ends are representable with no overflow.
- While out_valid=1 && out_ready=0, out_result and out_tag must stay stable (AXI-style hold).
- rst has priority over a transfer in the same cycle: the input is dropped.

Decomposition:
- Package vedic_pkg holds:
  - function mult_latency(width) returning LATENCY
  - localparam BASE_W = 4
  - legal-width check function
- One sub-module, vedic_mul_core: parametrised unsigned WIDTH x WIDTH core with en gating, built by generate recursion down to 4x4. It carries no valid, tag or sign.
- vedic_mult_pipe wraps it with:
  - the sign/magnitude front stage and negate back stage
  - the LATENCY-deep valid/tag/neg shift registers (all gated by en)
  - the handshake logic

Test Plan:
1. WIDTH=16, unsigned, a=0xFFFF, b=0xFFFF, out_ready=1 -> out_valid exactly 7 cycles after accept; out_result=0xFFFE0001; tag echoed.
2. WIDTH=16, signed: (a=0x8000,b=0x8000) -> 0x40000000; (0x8000,0x0001) -> 0xFFFF8000; (0xFFFF,0x0003) -> 0xFFFFFFFD.
3. WIDTH=16, 100 back-to-back random pairs with random mode, out_ready=1 -> one result per cycle, in order, matching the reference model and tags; no gaps.
4. Stall: 5 transactions in flight, out_ready=0 for 10 cycles -> in_ready=0, out_result/out_tag frozen. On release, all 5 emerge in order with no loss or duplicates.
5. Reset mid-operation: assert rst for 1 cycle with 4 transactions in flight -> out_valid=0 and out_result=0 the next cycle; the discarded results never appear; a new input at a=3,b=5 yields 15 after LATENCY.
6. Sweep WIDTH=8/32/64 with corner operands (0, 1, max, min-signed): latency 5/9/11, correct products including 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE00000001.
